// File: rtl/procyon_types.sv
// Shared address/data types and the ROM arbiter priority-state encoding.
package procyon_types;

    typedef logic [31:0] procyon_addr_t;
    typedef logic [31:0] procyon_data_t;

    typedef enum logic [0:0] {
        IFQ_PRI = 1'b0,
        LSU_PRI = 1'b1
    } rom_arb_state_t;

endpackage

// File: rtl/rom_arbiter.sv
// Two-port arbiter in front of a single combinational ROM: instruction fetch (IFQ)
// normally wins, with a starvation counter that hands priority to the LSU.
module rom_arbiter
    import procyon_types::*;
#(
    parameter int STARVE_LIMIT = 4,
    localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_flush,
    input  logic             i_ifq_req,
    input  procyon_addr_t    i_ifq_addr,
    output logic             o_ifq_gnt,
    output logic             o_ifq_valid,
    output procyon_data_t    o_ifq_data,
    input  logic             i_lsu_req,
    input  procyon_addr_t    i_lsu_addr,
    output logic             o_lsu_gnt,
    output logic             o_lsu_valid,
    output procyon_data_t    o_lsu_data,
    output procyon_addr_t    o_rom_addr,
    output logic             o_rom_en,
    input  procyon_data_t    i_rom_data,
    input  logic             i_rom_valid,
    output rom_arb_state_t   o_dbg_state,
    output logic [CNT_W-1:0] o_dbg_starve_cnt
);

    // Handshake: a request is accepted in the cycle its gnt is high (no back-pressure);
    // the matching o_x_valid is a single-cycle pulse on the following rising edge.

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    rom_arb_state_t   state_q;
    rom_arb_state_t   state_d;
    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;

    logic at_limit;
    logic lsu_first;
    logic ifq_live;
    logic ifq_gnt;
    logic lsu_gnt;

    // Grants are gated by n_rst so nothing is accepted while reset is held.
    always_comb begin
        at_limit  = (starve_q == LIMIT);
        lsu_first = (state_q == LSU_PRI) || at_limit;
        ifq_live  = n_rst && i_ifq_req && !i_flush;
        lsu_gnt   = n_rst && i_lsu_req && (!ifq_live || lsu_first);
        ifq_gnt   = ifq_live && !lsu_gnt;
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IFQ_PRI: if (at_limit && !lsu_gnt) state_d = LSU_PRI;
            LSU_PRI: if (lsu_gnt) state_d = IFQ_PRI;
            default: state_d = IFQ_PRI;
        endcase
        if (!i_lsu_req || lsu_gnt) begin
            starve_d = '0;
        end else if (!at_limit) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= IFQ_PRI;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        o_rom_addr = '0;
        if (ifq_gnt) begin
            o_rom_addr = i_ifq_addr;
        end else if (lsu_gnt) begin
            o_rom_addr = i_lsu_addr;
        end
    end

    // Data registers only load on their own grant so they hold the last word otherwise.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_ifq_valid <= 1'b0;
            o_ifq_data  <= '0;
            o_lsu_valid <= 1'b0;
            o_lsu_data  <= '0;
        end else begin
            o_ifq_valid <= ifq_gnt && i_rom_valid && !i_flush;
            o_lsu_valid <= lsu_gnt && i_rom_valid;
            if (ifq_gnt) o_ifq_data <= i_rom_data;
            if (lsu_gnt) o_lsu_data <= i_rom_data;
        end
    end

    assign o_ifq_gnt        = ifq_gnt;
    assign o_lsu_gnt        = lsu_gnt;
    assign o_rom_en         = ifq_gnt || lsu_gnt;
    assign o_dbg_state      = state_q;
    assign o_dbg_starve_cnt = starve_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a STARVE_LIMIT=4 and a STARVE_LIMIT=0 instance share stimulus.
module tb_rom_arbiter;
    import procyon_types::*;

    // clock / reset
    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    logic          flush     = 1'b0;
    logic          ifq_req   = 1'b1;
    logic          lsu_req   = 1'b1;
    logic          rom_valid = 1'b1;
    procyon_addr_t ifq_addr  = 32'h10;
    procyon_addr_t lsu_addr  = 32'h20;

    logic           ifq_gnt[2];
    logic           ifq_valid[2];
    logic           lsu_gnt[2];
    logic           lsu_valid[2];
    logic           rom_en[2];
    procyon_data_t  ifq_data[2];
    procyon_data_t  lsu_data[2];
    procyon_data_t  rom_data[2];
    procyon_addr_t  rom_addr[2];
    rom_arb_state_t dbg_state[2];
    logic [2:0]     cnt_a;
    logic [0:0]     cnt_b;

    function automatic procyon_data_t rom_fn(input procyon_addr_t a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign rom_data[0] = rom_fn(rom_addr[0]);
    assign rom_data[1] = rom_fn(rom_addr[1]);

    rom_arbiter #(.STARVE_LIMIT(4)) dut_a (
        .clk(clk), .n_rst(n_rst), .i_flush(flush),
        .i_ifq_req(ifq_req), .i_ifq_addr(ifq_addr), .o_ifq_gnt(ifq_gnt[0]),
        .o_ifq_valid(ifq_valid[0]), .o_ifq_data(ifq_data[0]),
        .i_lsu_req(lsu_req), .i_lsu_addr(lsu_addr), .o_lsu_gnt(lsu_gnt[0]),
        .o_lsu_valid(lsu_valid[0]), .o_lsu_data(lsu_data[0]),
        .o_rom_addr(rom_addr[0]), .o_rom_en(rom_en[0]),
        .i_rom_data(rom_data[0]), .i_rom_valid(rom_valid),
        .o_dbg_state(dbg_state[0]), .o_dbg_starve_cnt(cnt_a)
    );

    rom_arbiter #(.STARVE_LIMIT(0)) dut_b (
        .clk(clk), .n_rst(n_rst), .i_flush(flush),
        .i_ifq_req(ifq_req), .i_ifq_addr(ifq_addr), .o_ifq_gnt(ifq_gnt[1]),
        .o_ifq_valid(ifq_valid[1]), .o_ifq_data(ifq_data[1]),
        .i_lsu_req(lsu_req), .i_lsu_addr(lsu_addr), .o_lsu_gnt(lsu_gnt[1]),
        .o_lsu_valid(lsu_valid[1]), .o_lsu_data(lsu_data[1]),
        .o_rom_addr(rom_addr[1]), .o_rom_en(rom_en[1]),
        .i_rom_data(rom_data[1]), .i_rom_valid(rom_valid),
        .o_dbg_state(dbg_state[1]), .o_dbg_starve_cnt(cnt_b)
    );

    // scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    logic [65:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic fl, input logic iq, input procyon_addr_t ia,
                         input logic lq, input procyon_addr_t la, input logic rv);
        @(negedge clk);
        flush     = fl;
        ifq_req   = iq;
        ifq_addr  = ia;
        lsu_req   = lq;
        lsu_addr  = la;
        rom_valid = rv;
        #1;
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s_ifq_gnt%0d", tag, k), ifq_gnt[k], 0);
            check($sformatf("%s_lsu_gnt%0d", tag, k), lsu_gnt[k], 0);
            check($sformatf("%s_ifq_valid%0d", tag, k), ifq_valid[k], 0);
            check($sformatf("%s_lsu_valid%0d", tag, k), lsu_valid[k], 0);
            check($sformatf("%s_ifq_data%0d", tag, k), ifq_data[k], 0);
            check($sformatf("%s_lsu_data%0d", tag, k), lsu_data[k], 0);
            check($sformatf("%s_rom_en%0d", tag, k), rom_en[k], 0);
            check($sformatf("%s_rom_addr%0d", tag, k), rom_addr[k], 0);
            check($sformatf("%s_state%0d", tag, k), dbg_state[k], IFQ_PRI);
        end
        check($sformatf("%s_cnt_a", tag), cnt_a, 0);
        check($sformatf("%s_cnt_b", tag), cnt_b, 0);
    endtask

    // Reference model: LSU goes first once it has waited `lim` cycles, and keeps that
    // right until it is actually granted.
    int waits[2];
    bit owed[2];
    int lim[2] = '{4, 0};
    procyon_data_t m_ifq_d[2];
    procyon_data_t m_lsu_d[2];

    task automatic model_grant(input int k, output bit ig, output bit lg);
        bit lsu_turn;
        bit ifq_live;
        lsu_turn = owed[k] || (waits[k] >= lim[k]);
        ifq_live = ifq_req && !flush;
        lg = lsu_req && (!ifq_live || lsu_turn);
        ig = ifq_live && !lg;
    endtask

    task automatic model_advance(input int k, input bit lg);
        if (lg) owed[k] = 1'b0;
        else if (waits[k] >= lim[k]) owed[k] = 1'b1;
        if (!lsu_req || lg) waits[k] = 0;
        else if (waits[k] < lim[k]) waits[k] = waits[k] + 1;
    endtask

    typedef struct {
        logic          fl;
        logic          iq;
        logic          lq;
        logic          rv;
        procyon_addr_t ia;
        procyon_addr_t la;
        logic          ig;
        logic          lg;
        logic          iv;
        logic          lv;
    } vec_t;

    vec_t vecs[10];

    initial begin
        bit            ig;
        bit            lg;
        bit            g4;
        procyon_data_t exp_id;
        procyon_data_t exp_ld;
        procyon_addr_t ea;
        logic          prev_iv;
        logic [65:0]   e;

        //             fl    iq    lq    rv    ia         la         ig    lg    iv    lv
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h200, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'h14, 32'h204, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h18, 32'h208, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1c, 32'h20c, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 32'h240, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 32'h244, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h24, 32'h210, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h28, 32'h214, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h2c, 32'h218, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h30, 32'h21c, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset with both requesters active: nothing may be granted
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        ifq_req = 1'b0;
        lsu_req = 1'b0;
        n_rst   = 1'b1;

        // table-driven vectors on the STARVE_LIMIT=4 instance
        exp_id  = '0;
        exp_ld  = '0;
        prev_iv = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].fl, vecs[i].iq, vecs[i].ia, vecs[i].lq, vecs[i].la, vecs[i].rv);
            check($sformatf("vec%0d_ifq_valid_hold", i), ifq_valid[0], prev_iv);
            check($sformatf("vec%0d_ifq_gnt", i), ifq_gnt[0], vecs[i].ig);
            check($sformatf("vec%0d_lsu_gnt", i), lsu_gnt[0], vecs[i].lg);
            check($sformatf("vec%0d_rom_en", i), rom_en[0], vecs[i].ig | vecs[i].lg);
            ea = vecs[i].ig ? vecs[i].ia : (vecs[i].lg ? vecs[i].la : '0);
            check($sformatf("vec%0d_rom_addr", i), rom_addr[0], ea);
            if (vecs[i].ig) exp_id = rom_fn(vecs[i].ia);
            if (vecs[i].lg) exp_ld = rom_fn(vecs[i].la);
            after_edge();
            check($sformatf("vec%0d_ifq_valid", i), ifq_valid[0], vecs[i].iv);
            check($sformatf("vec%0d_lsu_valid", i), lsu_valid[0], vecs[i].lv);
            check($sformatf("vec%0d_ifq_data", i), ifq_data[0], exp_id);
            check($sformatf("vec%0d_lsu_data", i), lsu_data[0], exp_ld);
            prev_iv = vecs[i].iv;
        end

        // continuous contention: LSU every 5th cycle on limit 4, always on limit 0
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b1, 32'h100 + c, 1'b1, 32'h300 + c, 1'b1);
            g4 = (c == 4) || (c == 9);
            check($sformatf("starve_c%0d_lsu_gnt_l4", c), lsu_gnt[0], g4);
            check($sformatf("starve_c%0d_ifq_gnt_l4", c), ifq_gnt[0], !g4);
            check($sformatf("starve_c%0d_lsu_gnt_l0", c), lsu_gnt[1], 1);
            check($sformatf("starve_c%0d_ifq_gnt_l0", c), ifq_gnt[1], 0);
            after_edge();
            if (c == 3) check("starve_cnt_saturated", cnt_a, 4);
            if (c == 4) begin
                check("starve_cnt_cleared", cnt_a, 0);
                check("starve_state_back", dbg_state[0], IFQ_PRI);
            end
        end

        // reset right after an LSU grant drops the response
        drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h400, 1'b1);
        check("rst_mid_grant", lsu_gnt[0], 1);
        @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        drive(1'b0, 1'b1, 32'h500, 1'b1, 32'h504, 1'b1);
        check_reset_outputs("rst_hold");
        @(negedge clk);
        n_rst    = 1'b1;
        ifq_req  = 1'b0;
        lsu_addr = 32'h408;
        #1;
        check("rst_release_gnt_l4", lsu_gnt[0], 1);
        check("rst_release_gnt_l0", lsu_gnt[1], 1);
        after_edge();
        check("rst_release_valid", lsu_valid[0], 1);
        check("rst_release_data", lsu_data[0], rom_fn(32'h408));

        // randomized phase from a clean reset, checked against the model
        @(negedge clk);
        n_rst   = 1'b0;
        ifq_req = 1'b0;
        lsu_req = 1'b0;
        flush   = 1'b0;
        #1;
        check_reset_outputs("rst_rand");
        @(negedge clk);
        n_rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            waits[k]   = 0;
            owed[k]    = 1'b0;
            m_ifq_d[k] = '0;
            m_lsu_d[k] = '0;
        end

        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, $urandom(),
                  $urandom_range(0, 1) == 1, $urandom(), $urandom_range(0, 5) != 0);
            for (int k = 0; k < 2; k++) begin
                model_grant(k, ig, lg);
                check($sformatf("rand%0d_ifq_gnt%0d", n, k), ifq_gnt[k], ig);
                check($sformatf("rand%0d_lsu_gnt%0d", n, k), lsu_gnt[k], lg);
                check($sformatf("rand%0d_rom_en%0d", n, k), rom_en[k], ig | lg);
                ea = ig ? ifq_addr : (lg ? lsu_addr : '0);
                check($sformatf("rand%0d_rom_addr%0d", n, k), rom_addr[k], ea);
                if (ig) m_ifq_d[k] = rom_fn(ifq_addr);
                if (lg) m_lsu_d[k] = rom_fn(lsu_addr);
                exp_q.push_back({ig && rom_valid && !flush, m_ifq_d[k], lg && rom_valid, m_lsu_d[k]});
                model_advance(k, lg);
            end
            after_edge();
            for (int k = 0; k < 2; k++) begin
                e = exp_q.pop_front();
                check($sformatf("rand%0d_ifq_valid%0d", n, k), ifq_valid[k], e[65]);
                check($sformatf("rand%0d_ifq_data%0d", n, k), ifq_data[k], e[64:33]);
                check($sformatf("rand%0d_lsu_valid%0d", n, k), lsu_valid[k], e[32]);
                check($sformatf("rand%0d_lsu_data%0d", n, k), lsu_data[k], e[31:0]);
            end
            check($sformatf("rand%0d_cnt", n), cnt_a, waits[0]);
        end

        // report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, max consecutive cycles a pending LSU request waits while IFQ wins; 0 = LSU strict priority.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  clock, rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 i_flush  input  1  pipeline flush; cancels IFQ traffic.
REQ-006 i_ifq_req  input  1  instruction fetch request.
REQ-007 i_ifq_addr  input  procyon_addr_t  fetch byte address.
REQ-008 o_ifq_gnt  output  1  IFQ request accepted this cycle (combinational).
REQ-009 o_ifq_valid  output  1  registered IFQ response valid.
REQ-010 o_ifq_data  output  procyon_data_t  IFQ response word.
REQ-011 i_lsu_req  input  1  load request; held until granted.
REQ-012 i_lsu_addr  input  procyon_addr_t  load byte address.
REQ-013 o_lsu_gnt  output  1  LSU request accepted this cycle.
REQ-014 o_lsu_valid  output  1  registered LSU response valid.
REQ-015 o_lsu_data  output  procyon_data_t  LSU response word.
REQ-016 o_rom_addr  output  procyon_addr_t  ROM read address.
REQ-017 o_rom_en  output  1  ROM read enable.
REQ-018 i_rom_data  input  procyon_data_t  ROM word, combinational from o_rom_addr.
REQ-019 i_rom_valid  input  1  ROM data valid, same cycle.

Function
REQ-020 SHALL grant at most one requester per cycle; o_rom_en = o_ifq_gnt | o_lsu_gnt; o_rom_addr = granted address, else 0.
REQ-021 FSM states IFQ_PRI, LSU_PRI; IFQ_PRI: IFQ wins when both request; LSU_PRI: LSU wins.
REQ-022 Starve counter, width $clog2(STARVE_LIMIT+1): +1 each cycle i_lsu_req & !o_lsu_gnt, saturates at STARVE_LIMIT; clears on LSU grant or i_lsu_req low.
REQ-023 IFQ_PRI -> LSU_PRI when counter == STARVE_LIMIT (comb, same cycle); LSU_PRI -> IFQ_PRI on the LSU grant edge.
REQ-024 Lone requester SHALL be granted regardless of state.
REQ-025 i_flush high SHALL force o_ifq_gnt=0 that cycle; LSU may be granted that cycle.
REQ-026 Response latency one cycle: on edge after grant, o_x_valid = i_rom_valid & !i_flush (IFQ) / i_rom_valid (LSU), o_x_data = i_rom_data sampled in grant cycle.
REQ-027 o_x_valid SHALL be high exactly one cycle per grant; o_x_data holds last value when not granted.
REQ-028 i_flush high in cycle o_ifq_valid is high SHALL NOT retract it; consumer discards.
REQ-029 Addresses passed unmodified; no alignment check.

Reset
REQ-030 While n_rst low: state IFQ_PRI, counter 0, o_*_valid 0, o_*_data 0, o_*_gnt 0, o_rom_en 0, o_rom_addr 0.
REQ-031 Reset assertion mid-transaction SHALL drop the pending response; first grant possible in first cycle after n_rst rises.

Structure
REQ-032 procyon_types SHALL hold procyon_addr_t, procyon_data_t and rom_arb_state_t enum {IFQ_PRI, LSU_PRI}.
REQ-033 Single flat module; no sub-module; STARVE_LIMIT local parameter, not in package.

Verification
REQ-034 IFQ only, addr 0x10, ROM word 0xDEADBEEF -> o_ifq_gnt same cycle, o_ifq_valid/o_ifq_data=0xDEADBEEF next cycle, one cycle.
REQ-035 IFQ and LSU both requesting continuously, STARVE_LIMIT=4 -> IFQ granted cycles 0-3, LSU cycle 4, IFQ cycle 5 onward; counter back to 0.
REQ-036 STARVE_LIMIT=0, both requesting -> LSU granted every cycle it requests.
REQ-037 IFQ grant cycle with i_flush=1 and LSU request -> o_ifq_gnt=0, o_lsu_gnt=1, no o_ifq_valid next cycle.
REQ-038 i_rom_valid=0 in grant cycle -> o_x_valid=0 next cycle, o_x_data updated.
REQ-039 n_rst asserted cycle after LSU grant -> o_lsu_valid=0, all outputs 0 until release.
